// File: rtl/cell_bist_pkg.sv
// Shared definitions for the library-cell BIST sequencers: FSM encoding,
// vector count and reference truth tables for common 3-input cells.
package cell_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bist_state_t;

   localparam int unsigned NUM_VEC  = 8;
   localparam logic [2:0]  LAST_IDX = 3'(NUM_VEC - 1);

   localparam logic [7:0] TT_ND3  = 8'h7F;
   localparam logic [7:0] TT_AND3 = 8'h80;
   localparam logic [7:0] TT_OR3  = 8'hFE;
   localparam logic [7:0] TT_XOR3 = 8'h96;

endpackage

// File: rtl/cell_bist_settle_cnt.sv
// Per-vector settle counter: loadable down-counter with a zero flag that
// tells the sequencer when the current vector may be sampled.
module cell_bist_settle_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       dec,
   input  logic [3:0] load_val,
   output logic       zero
);

   logic [3:0] cnt_q;

   // Load has priority over decrement; decrement stops at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/cell3_bist_ctrl.sv
// Exhaustive truth-table sequencer for a single 3-input combinational cell.
// Walks all 8 input vectors, holds each for SETTLE+1 cycles, samples Z on
// the last cycle against a captured truth table and reports the result.
module cell3_bist_ctrl
   import cell_bist_pkg::*;
#(
   parameter int unsigned SETTLE     = 2,
   parameter logic [7:0]  TT_DEFAULT = 8'h7F
) (
   input  logic       CLK,
   input  logic       LSR,
   input  logic       START,
   input  logic       ABORT,
   input  logic [7:0] TT,
   input  logic       Z,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [3:0] ERRCNT,
   output logic [2:0] FAIL_IDX
);

   localparam logic [3:0] SETTLE_VAL = 4'(SETTLE);

   bist_state_t state;
   logic [2:0]  idx;
   logic [7:0]  tt_q;
   logic        mismatch;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_clr;
   logic        cnt_zero;

   assign mismatch = (Z != tt_q[idx]);

   // Settle-counter control derived from the current state and requests.
   always_comb begin
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = LSR;
      if (!LSR) begin
         if (state == ST_RUN) begin
            if (ABORT) begin
               cnt_clr = 1'b1;
            end else if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (idx != LAST_IDX) begin
               cnt_load = 1'b1;
            end
         end else if (START) begin
            cnt_load = 1'b1;
         end
      end
   end

   cell_bist_settle_cnt u_settle (
      .clk      (CLK),
      .rst      (cnt_clr),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (SETTLE_VAL),
      .zero     (cnt_zero)
   );

   // Sequencer FSM with registered outputs; ABORT beats the final sample.
   always_ff @(posedge CLK) begin
      if (LSR) begin
         state    <= ST_IDLE;
         idx      <= '0;
         tt_q     <= TT_DEFAULT;
         A        <= 1'b0;
         B        <= 1'b0;
         C        <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         PASS     <= 1'b0;
         ERRCNT   <= '0;
         FAIL_IDX <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  state     <= ST_RUN;
                  tt_q      <= TT;
                  idx       <= '0;
                  {A, B, C} <= '0;
                  BUSY      <= 1'b1;
                  DONE      <= 1'b0;
                  PASS      <= 1'b0;
                  ERRCNT    <= '0;
                  FAIL_IDX  <= '0;
               end
            end
            ST_RUN: begin
               if (ABORT) begin
                  state     <= ST_IDLE;
                  idx       <= '0;
                  {A, B, C} <= '0;
                  BUSY      <= 1'b0;
                  DONE      <= 1'b0;
                  PASS      <= 1'b0;
                  ERRCNT    <= '0;
                  FAIL_IDX  <= '0;
               end else if (cnt_zero) begin
                  if (mismatch) begin
                     ERRCNT <= ERRCNT + 4'd1;
                     if (ERRCNT == '0) begin
                        FAIL_IDX <= idx;
                     end
                  end
                  if (idx == LAST_IDX) begin
                     state     <= ST_DONE;
                     idx       <= '0;
                     {A, B, C} <= '0;
                     BUSY      <= 1'b0;
                     DONE      <= 1'b1;
                     PASS      <= (ERRCNT == '0) && !mismatch;
                  end else begin
                     idx       <= idx + 3'd1;
                     {A, B, C} <= idx + 3'd1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cell3_bist_ctrl.md
CELL3_BIST_CTRL -- requirements
Module: cell3_bist_ctrl

Exhaustive truth-table test sequencer for one 3-input combinational library cell. It drives all 8 input vectors, samples the cell output and reports the result.

Interface
REQ-001 Parameter SETTLE, default 2: extra hold cycles per vector before Z is sampled; legal range 0..15.
REQ-002 Parameter TT_DEFAULT, default 8'h7F: expected truth table loaded at reset (3-input NAND).
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 LSR  in  1  reset, synchronous, active-high.
REQ-005 START  in  1  one-cycle request to begin a test run.
REQ-006 ABORT  in  1  cancels a run in progress.
REQ-007 TT  in  8  expected truth table; bit i = expected Z for vector i.
REQ-008 Z  in  1  output of the cell under test.
REQ-009 A, B, C  out  1 each  cell inputs; vector index i maps to A=i[2], B=i[1], C=i[0].
REQ-010 BUSY  out  1  run in progress.
REQ-011 DONE  out  1  run complete; results valid.
REQ-012 PASS  out  1  DONE and zero mismatches.
REQ-013 ERRCNT  out  4  mismatch count, range 0..8.
REQ-014 FAIL_IDX  out  3  index of the first mismatching vector; 0 if none.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; state bits and all outputs are registered.
REQ-016 In IDLE or DONE, START=1 SHALL, at the next edge:
  - capture TT;
  - clear ERRCNT, FAIL_IDX, DONE and PASS;
  - set idx=0 and A/B/C=000;
  - load the settle counter with SETTLE;
  - enter RUN with BUSY=1.
REQ-017 In RUN with counter>0, the counter SHALL decrement and A/B/C SHALL hold, so each vector is driven for exactly SETTLE+1 cycles.
REQ-018 In RUN with counter==0, Z SHALL be compared with captured TT[idx] at that edge.
REQ-019 On a mismatch, ERRCNT SHALL increment; FAIL_IDX SHALL be written only on the first mismatch of the run.
REQ-020 In RUN with counter==0 and idx<7, idx SHALL increment, the next vector SHALL be driven and the counter SHALL reload with SETTLE.
REQ-021 In RUN with counter==0 and idx==7, the block SHALL:
  - enter DONE;
  - set BUSY=0 and DONE=1;
  - set PASS=(final ERRCNT==0);
  - return A/B/C to 000.
REQ-022 Run latency: START sampled at edge k SHALL give BUSY=1 for cycles k+1 .. k+8*(SETTLE+1), and DONE=1 from k+8*(SETTLE+1)+1.
REQ-023 START while BUSY SHALL be ignored.
REQ-024 TT changes during RUN SHALL have no effect; only the captured copy is used.
REQ-025 ABORT=1 in RUN SHALL, at the next edge, enter IDLE with BUSY=0, DONE=0, PASS=0, ERRCNT=0, FAIL_IDX=0 and A/B/C=000.
REQ-026 ABORT in IDLE or DONE SHALL be ignored.
REQ-027 ABORT SHALL take priority over a same-cycle final sample, so no DONE is produced.
REQ-028 DONE, PASS, ERRCNT and FAIL_IDX SHALL hold in DONE until the next accepted START or LSR.
REQ-029 ERRCNT SHALL be 4 bits wide; it cannot exceed 8, so it needs no saturation logic.

Reset
REQ-030 LSR=1 SHALL, at the edge, set:
  - state = IDLE;
  - A/B/C, BUSY, DONE, PASS = 0;
  - ERRCNT, FAIL_IDX, idx, counter = 0;
  - captured TT = TT_DEFAULT.
REQ-031 LSR SHALL override START and ABORT in the same cycle, including during a run.
REQ-032 START SHALL be accepted on the first edge after LSR deasserts.

Structure
REQ-033 Shared package cell_bist_pkg SHALL hold:
  - the FSM state encoding;
  - NUM_VEC=8;
  - truth-table constants TT_ND3=8'h7F, TT_AND3=8'h80, TT_OR3=8'hFE, TT_XOR3=8'h96.
REQ-034 The settle counter SHALL be one sub-module, cell_bist_settle_cnt, with load, decrement and zero-flag outputs.
REQ-035 All other logic SHALL sit in cell3_bist_ctrl.

Verification
REQ-036 SETTLE=2, TT=8'h7F, Z driven by an ideal 3-input NAND model, START at edge k -> BUSY high k+1..k+24; DONE=1 and PASS=1 from k+25; ERRCNT=0.
REQ-037 Same setup, but the model output stuck at 1 -> DONE with PASS=0, ERRCNT=1, FAIL_IDX=7.
REQ-038 Model output stuck at 0, TT=8'h7F -> ERRCNT=7, FAIL_IDX=0.
REQ-039 ABORT asserted 10 cycles after START -> BUSY=0, DONE=0, ERRCNT=0, A/B/C=000 next cycle; a later START completes a normal run.
REQ-040 LSR mid-run, plus START during BUSY, plus TT changed to 8'h00 mid-run -> reset clears all outputs; START during BUSY is ignored; the TT change does not affect the run result.
REQ-041 SETTLE=0, TT=8'h96, ideal 3-input XOR model -> 8 BUSY cycles, PASS=1.
